// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, derived bus widths and sequencer state encoding
package systolic_pkg;
  localparam int DEF_DATA_BW = 8;
  localparam int DEF_PARTIAL_SUM_BW = 19;
  localparam int DEF_MATRIX_SIZE = 8;
  localparam int DEF_NUM_PE_ROWS = 8;
  localparam int DEF_ARRAY_LAT = 9;
  localparam int DEF_WLOAD_CYC = 2;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_CNT_W = 16;
  localparam int VEC_W = DEF_MATRIX_SIZE * DEF_DATA_BW;
  localparam int RES_W = DEF_NUM_PE_ROWS * DEF_PARTIAL_SUM_BW;
  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} state_e;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; dout shows the head while cnt is non-zero
// Ports: clk, rst (sync, active high); push/din write; pop reads head (ignored when empty);
//   dout head data; empty flag; cnt entries held (0..DEPTH).
module sync_fifo_fwft #(
  parameter int W = 152,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [AW:0]  cnt
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic full, do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a push while full is only taken when the same cycle frees the head slot
  assign do_push = push && (!full || do_pop);
  assign dout = mem_q[rd_q];
  assign cnt = cnt_q;
  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk)
    if (!rst) assert (!(push && full && !pop));
endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: job sequencer feeding a weight-stationary systolic array with credit-gated input
// Ports: clk, rst (sync, active high); start/num_vec job request, busy, done pulse;
//   in_valid/in_ready/in_data input vectors; sa_we_rl, sa_din to the array, sa_result from it;
//   out_valid/out_ready/out_data result FIFO head.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_BW = DEF_DATA_BW,
  parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int NUM_PE_ROWS = DEF_NUM_PE_ROWS,
  parameter int ARRAY_LAT = DEF_ARRAY_LAT,
  parameter int WLOAD_CYC = DEF_WLOAD_CYC,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [CNT_W-1:0]                      num_vec,
  output logic                                  busy,
  output logic                                  done,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [MATRIX_SIZE*DATA_BW-1:0]        in_data,
  output logic                                  sa_we_rl,
  output logic [MATRIX_SIZE*DATA_BW-1:0]        sa_din,
  input  logic [NUM_PE_ROWS*PARTIAL_SUM_BW-1:0] sa_result,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_PE_ROWS*PARTIAL_SUM_BW-1:0] out_data
);
  localparam int VW = MATRIX_SIZE * DATA_BW;
  localparam int RW = NUM_PE_ROWS * PARTIAL_SUM_BW;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(WLOAD_CYC + 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d, acc_q, acc_d;
  logic [WW-1:0] wl_q, wl_d;
  // bit 0 is aligned with the cycle sa_din shows a vector; bit ARRAY_LAT with its result
  logic [ARRAY_LAT:0] vpipe_q, vpipe_d;
  logic [VW-1:0] sa_din_q, sa_din_d;
  logic [FW-1:0] fifo_cnt;
  logic [FW:0] occ;
  logic accept, fifo_empty;
  // every in-flight vector already owns a FIFO slot, so the array can never overrun it
  assign occ = {1'b0, fifo_cnt} + (FW+1)'($countones(vpipe_q));
  assign in_ready = state_q == FEED && acc_q < num_q && occ < (FW+1)'(FIFO_DEPTH);
  assign accept = in_valid && in_ready;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sa_we_rl = state_q == LOAD;
  assign sa_din = sa_din_q;
  assign out_valid = !fifo_empty;
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    acc_d = acc_q;
    wl_d = wl_q;
    sa_din_d = accept ? in_data : '0;
    vpipe_d = {vpipe_q[ARRAY_LAT-1:0], accept};
    case (state_q)
      IDLE:
        if (start) begin
          state_d = LOAD;
          num_d = num_vec;
          acc_d = '0;
          wl_d = '0;
        end
      LOAD: begin
        wl_d = wl_q + 1'b1;
        if (wl_q == WW'(WLOAD_CYC - 1)) state_d = num_q == '0 ? DONE : FEED;
      end
      FEED:
        if (accept) begin
          acc_d = acc_q + 1'b1;
          if (acc_d == num_q) state_d = DRAIN;
        end
      DRAIN: state_d = vpipe_q == '0 ? DONE : DRAIN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      num_q <= '0;
      acc_q <= '0;
      wl_q <= '0;
      vpipe_q <= '0;
      sa_din_q <= '0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      acc_q <= acc_d;
      wl_q <= wl_d;
      vpipe_q <= vpipe_d;
      sa_din_q <= sa_din_d;
    end
  sync_fifo_fwft #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(vpipe_q[ARRAY_LAT]),
    .din(sa_result),
    .pop(out_ready),
    .dout(out_data),
    .empty(fifo_empty),
    .cnt(fifo_cnt)
  );
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed table and job sequences against a delay-line array model and result scoreboard
module tb_systolic_seq_ctrl;
  import systolic_pkg::*;
  typedef struct packed {
    logic s;
    logic iv;
    logic ordy;
    logic [4:0] exp;
  } row_t;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [15:0] num_vec = 0;
  logic [VEC_W-1:0] in_data = '0;
  logic busy, done, in_ready, sa_we_rl, out_valid;
  logic [VEC_W-1:0] sa_din;
  logic [RES_W-1:0] sa_result, out_data;
  logic [VEC_W-1:0] hist [9] = '{default: '0};
  logic [VEC_W-1:0] q [$];
  logic [VEC_W-1:0] exp_din = '0;
  logic [4:0] st;
  row_t tbl [20];
  int n_vec = 0, n_bad = 0, sent = 0, done_cnt = 0, we_cnt = 0, ir_cnt = 0, ov_cnt = 0, max_out = 0;
  int cyc, c, d0, s0, ir0, ov0;
  always #5 clk = ~clk;
  systolic_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sa_we_rl(sa_we_rl),
    .sa_din(sa_din), .sa_result(sa_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );
  function automatic logic [VEC_W-1:0] mkvec(input int k);
    logic [VEC_W-1:0] v;
    v[7:0] = 8'(k);
    for (int i = 1; i < 8; i++) v[i*8+:8] = 8'(k * 7 + i * 31 + 3);
    return v;
  endfunction
  function automatic logic [RES_W-1:0] arr(input logic [VEC_W-1:0] v);
    logic [RES_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*19+:19] = {3'b0, v[i*8+:8], 8'(i * 17 + 5)};
    return r;
  endfunction
  // array model: result for the vector on sa_din appears 9 cycles later
  always @(posedge clk) begin
    hist[0] <= sa_din;
    for (int k = 1; k < 9; k++) hist[k] <= hist[k-1];
  end
  assign sa_result = arr(hist[8]);
  task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic s, input logic [15:0] nv, input logic iv, input logic ordy, output logic [4:0] o);
    logic [VEC_W-1:0] nxt;
    @(negedge clk);
    start = s;
    num_vec = nv;
    in_valid = iv;
    out_ready = ordy;
    in_data = mkvec(sent);
    #1;
    o = {busy, done, in_ready, sa_we_rl, out_valid};
    chk("sa_din", RES_W'(sa_din), RES_W'(exp_din));
    nxt = '0;
    if (in_valid && in_ready) begin
      q.push_back(in_data);
      nxt = in_data;
      sent++;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL pop_unexpected: got %0h expected no result", out_data);
      end else chk("pop", out_data, arr(q.pop_front()));
    end
    exp_din = nxt;
    if (q.size() > max_out) max_out = q.size();
    done_cnt += int'(done);
    we_cnt += int'(sa_we_rl);
    ir_cnt += int'(in_ready);
    ov_cnt += int'(out_valid);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    start = 0;
    in_valid = 0;
    out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    q.delete();
    exp_din = '0;
    #1;
    chk("rst_outs", RES_W'({busy, done, in_ready, sa_we_rl, out_valid}), '0);
    chk("rst_sa_din", RES_W'(sa_din), '0);
  endtask
  task automatic run_job(input logic [15:0] nv, input bit tog, input bit ordy, output int n);
    int d;
    d = done_cnt;
    step(1, nv, 0, ordy, st);
    n = 0;
    while (done_cnt == d && n < 500) begin
      step(0, nv, tog ? ~n[0] : 1'b1, ordy, st);
      n++;
    end
    chk("job_done", RES_W'(done_cnt - d), RES_W'(1));
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      step(0, 0, 0, 1, st);
      n++;
    end
    chk("drained", RES_W'(q.size()), '0);
  endtask
  initial begin
    tbl = '{
      '{1'b1, 1'b1, 1'b1, 5'b00000}, '{1'b0, 1'b1, 1'b1, 5'b10010}, '{1'b0, 1'b1, 1'b1, 5'b10010},
      '{1'b0, 1'b1, 1'b1, 5'b10100}, '{1'b0, 1'b1, 1'b1, 5'b10100}, '{1'b0, 1'b1, 1'b1, 5'b10100},
      '{1'b0, 1'b1, 1'b1, 5'b10100}, '{1'b0, 1'b1, 1'b1, 5'b10000}, '{1'b0, 1'b1, 1'b1, 5'b10000},
      '{1'b0, 1'b1, 1'b1, 5'b10000}, '{1'b0, 1'b1, 1'b1, 5'b10000}, '{1'b0, 1'b1, 1'b1, 5'b10000},
      '{1'b0, 1'b1, 1'b1, 5'b10000}, '{1'b0, 1'b1, 1'b1, 5'b10000}, '{1'b0, 1'b1, 1'b1, 5'b10001},
      '{1'b0, 1'b1, 1'b1, 5'b10001}, '{1'b0, 1'b1, 1'b1, 5'b10001}, '{1'b0, 1'b1, 1'b1, 5'b10001},
      '{1'b0, 1'b1, 1'b1, 5'b11000}, '{1'b0, 1'b1, 1'b1, 5'b00000}
    };
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].s, 16'd4, tbl[i].iv, tbl[i].ordy, st);
      chk($sformatf("tbl_c%0d", i), RES_W'(st), RES_W'(tbl[i].exp));
    end
    chk("basic_sent", RES_W'(sent), RES_W'(4));
    chk("basic_empty", RES_W'(q.size()), '0);
    we_cnt = 0;
    s0 = sent;
    run_job(16'd5, 1'b1, 1'b1, cyc);
    drain();
    chk("bub_sent", RES_W'(sent - s0), RES_W'(5));
    chk("bub_we", RES_W'(we_cnt), RES_W'(2));
    s0 = sent;
    max_out = 0;
    d0 = done_cnt;
    step(1, 16'd40, 0, 0, st);
    repeat (40) step(0, 16'd40, 1, 0, st);
    chk("bp_stall", RES_W'(q.size()), RES_W'(16));
    chk("bp_ready", RES_W'(in_ready), '0);
    chk("bp_ov", RES_W'(out_valid), RES_W'(1));
    c = 0;
    while (done_cnt == d0 && c < 500) begin
      step(0, 16'd40, 1, 1, st);
      c++;
    end
    drain();
    chk("bp_done", RES_W'(done_cnt - d0), RES_W'(1));
    chk("bp_sent", RES_W'(sent - s0), RES_W'(40));
    chk("bp_max", RES_W'(max_out), RES_W'(16));
    we_cnt = 0;
    ir0 = ir_cnt;
    ov0 = ov_cnt;
    s0 = sent;
    run_job(16'd0, 1'b0, 1'b1, cyc);
    chk("zero_len", RES_W'(cyc), RES_W'(3));
    chk("zero_we", RES_W'(we_cnt), RES_W'(2));
    chk("zero_ready", RES_W'(ir_cnt - ir0), '0);
    chk("zero_push", RES_W'(ov_cnt - ov0), '0);
    chk("zero_sent", RES_W'(sent - s0), '0);
    we_cnt = 0;
    d0 = done_cnt;
    s0 = sent;
    step(1, 16'd3, 0, 0, st);
    c = 0;
    while (done_cnt == d0 && c < 200) begin
      step(c == 5, c == 5 ? 16'd9 : 16'd3, 1, 0, st);
      c++;
    end
    step(1, 16'd2, 0, 0, st);
    c = 0;
    while (done_cnt == d0 + 1 && c < 200) begin
      step(0, 16'd2, 1, 0, st);
      c++;
    end
    chk("b2b_done", RES_W'(done_cnt - d0), RES_W'(2));
    chk("b2b_we", RES_W'(we_cnt), RES_W'(4));
    chk("b2b_sent", RES_W'(sent - s0), RES_W'(5));
    chk("b2b_fifo", RES_W'(q.size()), RES_W'(5));
    drain();
    step(1, 16'd20, 0, 0, st);
    repeat (15) step(0, 16'd20, 1, 0, st);
    chk("pre_rst", RES_W'({busy, out_valid}), RES_W'(2'b11));
    do_reset();
    run_job(16'd2, 1'b0, 1'b1, cyc);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
